// File: rtl/data_mem_if.sv
// Processor data-port bus: byte address, write strobe/data and combinational read data.
interface data_mem_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output addr, output we, output wd, input rd);
    modport slave  (input addr, input we, input wd, output rd);
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus LED, switch, cycle counter and countdown timer
// registers, all answering reads combinationally in the same cycle as the address.
module data_mem_responder #(
    parameter int RAM_WORDS = 64,
    parameter int LED_WIDTH = 8,
    parameter int SW_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_if.slave            bus,
    input  logic [SW_WIDTH-1:0]  sw,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 timer_done
);
    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [29:0] WORD_LED    = 30'h100;
    localparam logic [29:0] WORD_SW     = 30'h101;
    localparam logic [29:0] WORD_CYCLES = 30'h102;
    localparam logic [29:0] WORD_TIMER  = 30'h103;
    localparam logic [29:0] WORD_STATUS = 30'h104;

    logic [31:0]          ram_reg [RAM_WORDS];
    logic [LED_WIDTH-1:0] led_reg;
    logic [SW_WIDTH-1:0]  sw_meta_reg;
    logic [SW_WIDTH-1:0]  sw_sync_reg;
    logic [31:0]          cycles_reg;
    logic [31:0]          timer_reg;
    logic                 done_reg;

    logic [29:0]   word;
    logic [AW-1:0] ram_idx;
    logic          is_ram;
    logic          wr_led;
    logic          wr_timer;
    logic          wr_status;
    logic          unused_addr_bits;

    assign word             = bus.addr[31:2];
    assign ram_idx          = bus.addr[AW+1:2];
    assign is_ram           = (bus.addr[31:10] == 22'd0);
    assign wr_led           = bus.we && (word == WORD_LED);
    assign wr_timer         = bus.we && (word == WORD_TIMER);
    assign wr_status        = bus.we && (word == WORD_STATUS);
    assign unused_addr_bits = ^bus.addr[1:0];

    // RAM contents are deliberately left out of reset so the array maps onto plain memory.
    always_ff @(posedge clk) begin
        if (bus.we && is_ram) begin
            ram_reg[ram_idx] <= bus.wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_reg     <= '0;
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
            cycles_reg  <= '0;
        end else begin
            if (wr_led) begin
                led_reg <= bus.wd[LED_WIDTH-1:0];
            end
            sw_meta_reg <= sw;
            sw_sync_reg <= sw_meta_reg;
            cycles_reg  <= cycles_reg + 32'd1;
        end
    end

    // done sets only when the count decrements 1->0; a load on that edge pre-empts it,
    // and a coincident STATUS write loses to the set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            if (wr_timer) begin
                timer_reg <= bus.wd;
            end else if (timer_reg != 32'd0) begin
                timer_reg <= timer_reg - 32'd1;
            end

            if (!wr_timer && (timer_reg == 32'd1)) begin
                done_reg <= 1'b1;
            end else if (wr_status) begin
                done_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rd = '0;
        if (is_ram) begin
            bus.rd = ram_reg[ram_idx];
        end else begin
            case (word)
                WORD_LED:    bus.rd = 32'(led_reg);
                WORD_SW:     bus.rd = 32'(sw_sync_reg);
                WORD_CYCLES: bus.rd = cycles_reg;
                WORD_TIMER:  bus.rd = timer_reg;
                WORD_STATUS: bus.rd = {31'd0, done_reg};
                default:     bus.rd = '0;
            endcase
        end
    end

    assign leds       = led_reg;
    assign timer_done = done_reg;
endmodule
